// File: rtl/alu_seq_if.sv
// Handshake and operand/result bus between the operand-fetch stage and alu_seq.
// The master drives the operation and out_ready; the slave (the ALU) answers with
// in_ready and the registered result.
interface alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] operand_0;
   logic [XLEN-1:0] operand_1;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] destination;
   logic            illegal;

   modport master (
      output in_valid, funct3, funct7, operand_0, operand_1, out_ready,
      input  in_ready, out_valid, destination, illegal
   );

   modport slave (
      input  in_valid, funct3, funct7, operand_0, operand_1, out_ready,
      output in_ready, out_valid, destination, illegal
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential RV32I register-register ALU with optional MUL.
// Logic, add/sub and compares finish in one cycle; shifts step SHIFT_STEP bits
// per cycle and MUL is a shift-add loop of exactly XLEN cycles. The result sits
// in an output register that holds while the consumer stalls.
module alu_seq #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1,
   parameter int ENABLE_MUL = 1
) (
   input logic       clock,
   input logic       reset_n,
   alu_seq_if.slave  bus
);
   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
   typedef enum logic [1:0] {K_SINGLE, K_SHIFT, K_MUL, K_ILLEGAL} kind_t;

   state_t          state_r;
   logic [CW-1:0]   count_r;
   logic [XLEN-1:0] work_r;
   logic            shift_left_r;
   logic            shift_arith_r;
   logic [XLEN-1:0] mcand_r;
   logic [XLEN-1:0] mplier_r;
   logic [XLEN-1:0] acc_r;
   logic            out_valid_r;
   logic [XLEN-1:0] dest_r;
   logic            illegal_r;

   kind_t           kind_s;
   logic [XLEN-1:0] single_res_s;
   logic            shift_left_s;
   logic            shift_arith_s;
   logic [SW-1:0]   shamt_s;
   logic            shamt_zero_s;
   logic [XLEN-1:0] sum_s;
   logic [XLEN-1:0] diff_s;
   logic            slt_s;
   logic            sltu_s;
   logic [CW-1:0]   step_amt_s;
   logic [XLEN-1:0] shifted_s;
   logic [XLEN-1:0] mul_add_s;
   logic            in_ready_s;
   logic            accept_s;

   assign shamt_s      = bus.operand_1[SW-1:0];
   assign shamt_zero_s = (shamt_s == {SW{1'b0}});
   assign sum_s        = bus.operand_0 + bus.operand_1;
   assign diff_s       = bus.operand_0 - bus.operand_1;
   assign slt_s        = ($signed(bus.operand_0) < $signed(bus.operand_1));
   assign sltu_s       = (bus.operand_0 < bus.operand_1);

   // Last partial step takes only the remaining count so the total is exact.
   assign step_amt_s = (count_r < CW'(SHIFT_STEP)) ? count_r : CW'(SHIFT_STEP);
   assign mul_add_s  = acc_r + (mplier_r[0] ? mcand_r : {XLEN{1'b0}});

   assign in_ready_s = reset_n & (state_r == S_IDLE) & (~out_valid_r | bus.out_ready);
   assign accept_s   = bus.in_valid & in_ready_s;

   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_r;
   assign bus.destination = dest_r;
   assign bus.illegal     = illegal_r;

   // Decode funct7/funct3 into an operation class and the single-cycle result.
   always_comb begin
      kind_s        = K_ILLEGAL;
      single_res_s  = {XLEN{1'b0}};
      shift_left_s  = 1'b0;
      shift_arith_s = 1'b0;
      case (bus.funct7)
         7'b0000000: begin
            case (bus.funct3)
               3'b000: begin kind_s = K_SINGLE; single_res_s = sum_s; end
               3'b001: begin
                  kind_s       = shamt_zero_s ? K_SINGLE : K_SHIFT;
                  single_res_s = bus.operand_0;
                  shift_left_s = 1'b1;
               end
               3'b010: begin kind_s = K_SINGLE; single_res_s = {{(XLEN-1){1'b0}}, slt_s}; end
               3'b011: begin kind_s = K_SINGLE; single_res_s = {{(XLEN-1){1'b0}}, sltu_s}; end
               3'b100: begin kind_s = K_SINGLE; single_res_s = bus.operand_0 ^ bus.operand_1; end
               3'b101: begin
                  kind_s       = shamt_zero_s ? K_SINGLE : K_SHIFT;
                  single_res_s = bus.operand_0;
               end
               3'b110: begin kind_s = K_SINGLE; single_res_s = bus.operand_0 | bus.operand_1; end
               3'b111: begin kind_s = K_SINGLE; single_res_s = bus.operand_0 & bus.operand_1; end
               default: kind_s = K_ILLEGAL;
            endcase
         end
         7'b0100000: begin
            case (bus.funct3)
               3'b000: begin kind_s = K_SINGLE; single_res_s = diff_s; end
               3'b101: begin
                  kind_s        = shamt_zero_s ? K_SINGLE : K_SHIFT;
                  single_res_s  = bus.operand_0;
                  shift_arith_s = 1'b1;
               end
               default: kind_s = K_ILLEGAL;
            endcase
         end
         7'b0000001: begin
            kind_s = ((bus.funct3 == 3'b000) && (ENABLE_MUL != 0)) ? K_MUL : K_ILLEGAL;
         end
         default: kind_s = K_ILLEGAL;
      endcase
   end

   // One shifter step; SRA keeps replicating the working MSB, which is operand_0's sign.
   always_comb begin
      if (shift_left_r) begin
         shifted_s = work_r << step_amt_s;
      end else if (shift_arith_r) begin
         shifted_s = $unsigned($signed(work_r) >>> step_amt_s);
      end else begin
         shifted_s = work_r >> step_amt_s;
      end
   end

   // Control FSM, iterative datapath and output register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r       <= S_IDLE;
         count_r       <= {CW{1'b0}};
         work_r        <= {XLEN{1'b0}};
         shift_left_r  <= 1'b0;
         shift_arith_r <= 1'b0;
         mcand_r       <= {XLEN{1'b0}};
         mplier_r      <= {XLEN{1'b0}};
         acc_r         <= {XLEN{1'b0}};
         out_valid_r   <= 1'b0;
         dest_r        <= {XLEN{1'b0}};
         illegal_r     <= 1'b0;
      end else begin
         // A consumed result frees the register; a new load below overrides this.
         if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  case (kind_s)
                     K_SHIFT: begin
                        state_r       <= S_SHIFT;
                        work_r        <= bus.operand_0;
                        count_r       <= {1'b0, shamt_s};
                        shift_left_r  <= shift_left_s;
                        shift_arith_r <= shift_arith_s;
                     end
                     K_MUL: begin
                        state_r  <= S_MUL;
                        mcand_r  <= bus.operand_0;
                        mplier_r <= bus.operand_1;
                        acc_r    <= {XLEN{1'b0}};
                        count_r  <= CW'(XLEN);
                     end
                     K_ILLEGAL: begin
                        out_valid_r <= 1'b1;
                        dest_r      <= {XLEN{1'b0}};
                        illegal_r   <= 1'b1;
                     end
                     default: begin
                        out_valid_r <= 1'b1;
                        dest_r      <= single_res_s;
                        illegal_r   <= 1'b0;
                     end
                  endcase
               end
            end
            S_SHIFT: begin
               work_r  <= shifted_s;
               count_r <= count_r - step_amt_s;
               if (count_r == step_amt_s) begin
                  state_r     <= S_IDLE;
                  out_valid_r <= 1'b1;
                  dest_r      <= shifted_s;
                  illegal_r   <= 1'b0;
               end
            end
            S_MUL: begin
               acc_r    <= mul_add_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               count_r  <= count_r - CW'(1);
               if (count_r == CW'(1)) begin
                  state_r     <= S_IDLE;
                  out_valid_r <= 1'b1;
                  dest_r      <= mul_add_s;
                  illegal_r   <= 1'b0;
               end
            end
            default: state_r <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: three instances share operand/opcode stimulus
// (SHIFT_STEP=1 with MUL, SHIFT_STEP=4, and MUL disabled), each with its own valid.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        va, vb, vc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] op0, op1;
   logic        ordy;
   logic        seen;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.XLEN(32)) a_if ();
   alu_seq_if #(.XLEN(32)) b_if ();
   alu_seq_if #(.XLEN(32)) c_if ();

   assign a_if.in_valid = va;  assign b_if.in_valid = vb;  assign c_if.in_valid = vc;
   assign a_if.funct3 = f3;    assign b_if.funct3 = f3;    assign c_if.funct3 = f3;
   assign a_if.funct7 = f7;    assign b_if.funct7 = f7;    assign c_if.funct7 = f7;
   assign a_if.operand_0 = op0; assign b_if.operand_0 = op0; assign c_if.operand_0 = op0;
   assign a_if.operand_1 = op1; assign b_if.operand_1 = op1; assign c_if.operand_1 = op1;
   assign a_if.out_ready = ordy; assign b_if.out_ready = ordy; assign c_if.out_ready = ordy;

   alu_seq #(.XLEN(32), .SHIFT_STEP(1), .ENABLE_MUL(1)) dut_a (.clock(clk), .reset_n(rst_n), .bus(a_if.slave));
   alu_seq #(.XLEN(32), .SHIFT_STEP(4), .ENABLE_MUL(1)) dut_b (.clock(clk), .reset_n(rst_n), .bus(b_if.slave));
   alu_seq #(.XLEN(32), .SHIFT_STEP(1), .ENABLE_MUL(0)) dut_c (.clock(clk), .reset_n(rst_n), .bus(c_if.slave));

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setop(input logic [6:0] f7v, input logic [2:0] f3v,
                        input logic [31:0] a, input logic [31:0] b);
      f7 = f7v; f3 = f3v; op0 = a; op1 = b;
   endtask

   initial begin
      rst_n = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0; ordy = 1'b1; seen = 1'b0;
      setop(7'b0000000, 3'b000, 32'h0, 32'h0);
      tick(); tick();
      chk1("rst_in_ready", a_if.in_ready, 1'b0);
      chk1("rst_out_valid", a_if.out_valid, 1'b0);
      chk32("rst_dest", a_if.destination, 32'h0);
      chk1("rst_illegal", a_if.illegal, 1'b0);
      rst_n = 1'b1; #1;
      chk1("post_rst_ready", a_if.in_ready, 1'b1);

      // ADD wrap, then SUB underflow, back-to-back
      setop(7'b0000000, 3'b000, 32'hFFFF_FFFF, 32'h1); va = 1'b1; tick();
      chk1("add_valid", a_if.out_valid, 1'b1);
      chk32("add_dest", a_if.destination, 32'h0);
      chk1("add_illegal", a_if.illegal, 1'b0);
      setop(7'b0100000, 3'b000, 32'h0, 32'h1); tick();
      chk1("sub_valid", a_if.out_valid, 1'b1);
      chk32("sub_dest", a_if.destination, 32'hFFFF_FFFF);

      // SLT / SLTU back-to-back with in_ready held high
      setop(7'b0000000, 3'b010, 32'h8000_0000, 32'h1); #1;
      chk1("slt_ready", a_if.in_ready, 1'b1);
      tick();
      chk32("slt_dest", a_if.destination, 32'h1);
      setop(7'b0000000, 3'b011, 32'h8000_0000, 32'h1); #1;
      chk1("sltu_ready", a_if.in_ready, 1'b1);
      tick();
      chk1("sltu_valid", a_if.out_valid, 1'b1);
      chk32("sltu_dest", a_if.destination, 32'h0);
      va = 1'b0; tick();
      chk1("idle_valid_clear", a_if.out_valid, 1'b0);

      // SRA by 31 on step-1 and step-4 instances
      setop(7'b0100000, 3'b101, 32'h8000_0000, 32'h1F); va = 1'b1; vb = 1'b1; tick();
      va = 1'b0; vb = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         if (k <= 31) begin
            chk1("sra1_busy_ready", a_if.in_ready, 1'b0);
            chk1("sra1_busy_valid", a_if.out_valid, 1'b0);
         end else begin
            chk1("sra1_valid", a_if.out_valid, 1'b1);
            chk32("sra1_dest", a_if.destination, 32'hFFFF_FFFF);
         end
         if (k == 8) chk1("sra4_early_valid", b_if.out_valid, 1'b0);
         if (k == 9) begin
            chk1("sra4_valid", b_if.out_valid, 1'b1);
            chk32("sra4_dest", b_if.destination, 32'hFFFF_FFFF);
         end
         if (k < 32) tick();
      end

      // SLL by 0 (upper shamt bits ignored) completes at N+1
      setop(7'b0000000, 3'b001, 32'h1234_5678, 32'h20); va = 1'b1; #1;
      chk1("sll0_ready", a_if.in_ready, 1'b1);
      tick(); va = 1'b0;
      chk1("sll0_valid", a_if.out_valid, 1'b1);
      chk32("sll0_dest", a_if.destination, 32'h1234_5678);

      // SRL by 5 with step 4: two shift cycles
      setop(7'b0000000, 3'b101, 32'hF000_0000, 32'h5); vb = 1'b1; tick(); vb = 1'b0;
      chk1("srl4_n1_valid", b_if.out_valid, 1'b0);
      tick();
      chk1("srl4_n2_valid", b_if.out_valid, 1'b0);
      tick();
      chk1("srl4_valid", b_if.out_valid, 1'b1);
      chk32("srl4_dest", b_if.destination, 32'h0780_0000);

      // MUL on the MUL-enabled and MUL-disabled instances
      setop(7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'h3); va = 1'b1; vc = 1'b1; tick();
      va = 1'b0; vc = 1'b0;
      chk1("nomul_valid", c_if.out_valid, 1'b1);
      chk1("nomul_illegal", c_if.illegal, 1'b1);
      chk32("nomul_dest", c_if.destination, 32'h0);
      for (int k = 1; k <= 33; k++) begin
         if (k == 32) chk1("mul_early_valid", a_if.out_valid, 1'b0);
         if (k == 33) begin
            chk1("mul_valid", a_if.out_valid, 1'b1);
            chk32("mul_dest", a_if.destination, 32'hFFFF_FFFD);
            chk1("mul_illegal", a_if.illegal, 1'b0);
         end
         if (k < 33) tick();
      end

      // Backpressure on an XOR result; a pending AND waits
      setop(7'b0000000, 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000); va = 1'b1; #1; tick();
      ordy = 1'b0;
      setop(7'b0000000, 3'b111, 32'hFF00_FF00, 32'h0FF0_0FF0); #1;
      chk1("xor_valid", a_if.out_valid, 1'b1);
      chk32("xor_dest", a_if.destination, 32'h0F0F_F0F0);
      chk1("stall_ready", a_if.in_ready, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk32("stall_dest_hold", a_if.destination, 32'h0F0F_F0F0);
         chk1("stall_valid_hold", a_if.out_valid, 1'b1);
         chk1("stall_ready_low", a_if.in_ready, 1'b0);
      end
      ordy = 1'b1; #1;
      chk1("release_ready", a_if.in_ready, 1'b1);
      tick(); va = 1'b0;
      chk1("and_valid", a_if.out_valid, 1'b1);
      chk32("and_dest", a_if.destination, 32'h0F00_0F00);
      tick();
      chk1("and_drained", a_if.out_valid, 1'b0);

      // Reset in cycle 10 of a MUL aborts it
      setop(7'b0000001, 3'b000, 32'h7, 32'h9); va = 1'b1; tick(); va = 1'b0;
      repeat (9) tick();
      chk1("mul_abort_pre_valid", a_if.out_valid, 1'b0);
      rst_n = 1'b0; #1;
      chk1("mid_rst_ready", a_if.in_ready, 1'b0);
      tick();
      chk1("mid_rst_valid", a_if.out_valid, 1'b0);
      rst_n = 1'b1; #1;
      chk1("after_rst_ready", a_if.in_ready, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 36; k++) begin
         tick();
         if (a_if.out_valid) seen = 1'b1;
      end
      chk1("abort_no_result", seen, 1'b0);

      // Illegal encodings, then a legal op clears the flag
      setop(7'b0100000, 3'b100, 32'h5, 32'h6); va = 1'b1; #1; tick();
      chk1("ill1_valid", a_if.out_valid, 1'b1);
      chk1("ill1_illegal", a_if.illegal, 1'b1);
      chk32("ill1_dest", a_if.destination, 32'h0);
      setop(7'b0000001, 3'b001, 32'h5, 32'h6); tick();
      chk1("ill2_illegal", a_if.illegal, 1'b1);
      setop(7'b1111111, 3'b000, 32'h5, 32'h6); tick();
      chk1("ill3_illegal", a_if.illegal, 1'b1);
      chk32("ill3_dest", a_if.destination, 32'h0);
      setop(7'b0000000, 3'b000, 32'h5, 32'h6); tick(); va = 1'b0;
      chk1("legal_after_ill", a_if.illegal, 1'b0);
      chk32("legal_after_dest", a_if.destination, 32'hB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
